// File: rtl/button_input.sv
// Button front end: 2-flop synchronizers, one debounce channel per button,
// and a fire auto-repeat FSM. Every output comes straight from a flop.
module button_input #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int CNT_W           = 18
) (
  input  logic clk,
  input  logic arst_n,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  input  logic btn_fire_raw,
  output logic left,
  output logic right,
  output logic fire,
  output logic fire_pulse,
  output logic any_press
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HELD = 1'b1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic             RPT_EN   = (REPEAT_CYCLES > 0);

  // Channel index: 0 = left, 1 = right, 2 = fire.
  logic [2:0] raw;

  logic [2:0]            sync1_q, sync1_d;
  logic [2:0]            sync2_q, sync2_d;
  logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]            lvl_q, lvl_d;
  logic [2:0]            lvl_prev_q, lvl_prev_d;
  logic                  any_press_q, any_press_d;
  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      rpt_q, rpt_d;
  logic                  fire_pulse_q, fire_pulse_d;

  assign raw = {btn_fire_raw, btn_right_raw, btn_left_raw};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  // The count only advances while the synchronized input disagrees with the
  // debounced level; any agreement restarts it, so glitches never accumulate.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      lvl_d[i] = lvl_q[i];
      if (sync2_q[i] != lvl_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lvl_prev_d  = lvl_q;
    any_press_d = |(lvl_q & ~lvl_prev_q);
  end

  // IDLE only ever sees fire high right after it rose, since HELD leaves as
  // soon as fire drops; the repeat counter stays at 0 when repeat is off.
  always_comb begin
    state_d      = state_q;
    rpt_d        = rpt_q;
    fire_pulse_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (lvl_q[2]) begin
        fire_pulse_d = 1'b1;
        rpt_d        = '0;
        state_d      = ST_HELD;
      end
    end else begin
      if (!lvl_q[2]) begin
        rpt_d   = '0;
        state_d = ST_IDLE;
      end else if (RPT_EN) begin
        if (rpt_q == RPT_LAST) begin
          fire_pulse_d = 1'b1;
          rpt_d        = '0;
        end else begin
          rpt_d = rpt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      cnt_q        <= '0;
      lvl_q        <= '0;
      lvl_prev_q   <= '0;
      any_press_q  <= 1'b0;
      state_q      <= ST_IDLE;
      rpt_q        <= '0;
      fire_pulse_q <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      cnt_q        <= cnt_d;
      lvl_q        <= lvl_d;
      lvl_prev_q   <= lvl_prev_d;
      any_press_q  <= any_press_d;
      state_q      <= state_d;
      rpt_q        <= rpt_d;
      fire_pulse_q <= fire_pulse_d;
    end
  end

  assign left       = lvl_q[0];
  assign right      = lvl_q[1];
  assign fire       = lvl_q[2];
  assign fire_pulse = fire_pulse_q;
  assign any_press  = any_press_q;

endmodule

// File: tb/tb_button_input.sv
// Bench for button_input (debounce 8, repeat 5, plus a repeat-0 copy);
// pulse events are scoreboarded as cycle*4+kind (0 any, 1 fire, 2 fire of repeat-0 copy).
module tb_button_input;

  logic clk = 1'b0;
  logic arst_n;
  logic btn_left_raw, btn_right_raw, btn_fire_raw;
  logic left, right, fire, fire_pulse, any_press;
  logic left0, right0, fire0, fire_pulse0, any_press0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_ev[$];
  int got_ev[$];
  int rd = 0;

  button_input #(.DEBOUNCE_CYCLES(8), .REPEAT_CYCLES(5), .CNT_W(4)) dut (
    .clk(clk), .arst_n(arst_n),
    .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw), .btn_fire_raw(btn_fire_raw),
    .left(left), .right(right), .fire(fire), .fire_pulse(fire_pulse), .any_press(any_press)
  );

  button_input #(.DEBOUNCE_CYCLES(8), .REPEAT_CYCLES(0), .CNT_W(4)) dut0 (
    .clk(clk), .arst_n(arst_n),
    .btn_left_raw(btn_left_raw), .btn_right_raw(btn_right_raw), .btn_fire_raw(btn_fire_raw),
    .left(left0), .right(right0), .fire(fire0), .fire_pulse(fire_pulse0), .any_press(any_press0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (any_press)   got_ev.push_back(cyc * 4);
    if (fire_pulse)  got_ev.push_back(cyc * 4 + 1);
    if (fire_pulse0) got_ev.push_back(cyc * 4 + 2);
  end

  function automatic string evs(input int v);
    case (v % 4)
      0:       return $sformatf("any_press@%0d", v / 4);
      1:       return $sformatf("fire_pulse@%0d", v / 4);
      default: return $sformatf("fire_pulse_rpt0@%0d", v / 4);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic test_reset();
    int c, e;
    btn_left_raw = 1'b1; btn_right_raw = 1'b1; btn_fire_raw = 1'b1;
    repeat (3) step();
    checks++;
    if ({left, right, fire, fire_pulse, any_press} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, expected 00000", {left, right, fire, fire_pulse, any_press});
    end
    checks++;
    if ({left0, right0, fire0, fire_pulse0, any_press0} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs_rpt0: got %b, expected 00000", {left0, right0, fire0, fire_pulse0, any_press0});
    end
    arst_n = 1'b1;
    c = cyc;
    exp_ev.push_back((c + 11) * 4);
    exp_ev.push_back((c + 11) * 4 + 2);
    for (int p = c + 11; p <= c + 21; p += 5) exp_ev.push_back(p * 4 + 1);
    step_to(c + 9);
    checks++;
    if ({left, right, fire} !== 3'b000) begin
      failures++;
      $display("FAIL reset_level_early: got %b, expected 000", {left, right, fire});
    end
    step();
    checks++;
    if ({left, right, fire} !== 3'b111) begin
      failures++;
      $display("FAIL reset_level_rise: got %b, expected 111", {left, right, fire});
    end
    step_to(c + 11);
    btn_left_raw = 1'b0; btn_right_raw = 1'b0; btn_fire_raw = 1'b0;
    step_to(c + 20);
    checks++;
    if ({left, right, fire} !== 3'b111) begin
      failures++;
      $display("FAIL reset_level_hold: got %b, expected 111", {left, right, fire});
    end
    step();
    checks++;
    if ({left, right, fire} !== 3'b000) begin
      failures++;
      $display("FAIL reset_level_fall: got %b, expected 000", {left, right, fire});
    end
    step_to(c + 40);
    exp_ev.sort();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (rd >= got_ev.size()) begin
        failures++;
        $display("FAIL reset_pulses: got nothing, expected %s", evs(e));
      end else begin
        if (got_ev[rd] !== e) begin
          failures++;
          $display("FAIL reset_pulses: got %s, expected %s", evs(got_ev[rd]), evs(e));
        end
        rd++;
      end
    end
    checks++;
    if (rd != got_ev.size()) begin
      failures++;
      $display("FAIL reset_pulses: got extra %s, expected none", evs(got_ev[rd]));
      rd = got_ev.size();
    end
  endtask

  task automatic test_glitch();
    int c, e;
    c = cyc;
    for (int k = 0; k < 26; k++) begin
      btn_left_raw = (k != 7 && k != 15);
      checks++;
      if (left !== 1'b0 || right !== 1'b0) begin
        failures++;
        $display("FAIL glitch_hold_low: got left=%b right=%b at cycle %0d, expected 0 0", left, right, cyc);
      end
      step();
    end
    checks++;
    if (left !== 1'b1) begin
      failures++;
      $display("FAIL glitch_stable_rise: got left=%b, expected 1", left);
    end
    exp_ev.push_back((c + 27) * 4);
    step_to(c + 35);
    exp_ev.sort();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (rd >= got_ev.size()) begin
        failures++;
        $display("FAIL glitch_pulses: got nothing, expected %s", evs(e));
      end else begin
        if (got_ev[rd] !== e) begin
          failures++;
          $display("FAIL glitch_pulses: got %s, expected %s", evs(got_ev[rd]), evs(e));
        end
        rd++;
      end
    end
    checks++;
    if (rd != got_ev.size()) begin
      failures++;
      $display("FAIL glitch_pulses: got extra %s, expected none", evs(got_ev[rd]));
      rd = got_ev.size();
    end
  endtask

  task automatic test_release();
    int c;
    logic exp_left;
    c = cyc;
    btn_left_raw = 1'b0;
    for (int k = 0; k < 20; k++) begin
      exp_left = (k < 10);
      checks++;
      if (left !== exp_left) begin
        failures++;
        $display("FAIL release_level: got left=%b at cycle %0d, expected %b", left, cyc, exp_left);
      end
      step();
    end
    step_to(c + 30);
    checks++;
    if (rd != got_ev.size()) begin
      failures++;
      $display("FAIL release_pulses: got extra %s, expected none", evs(got_ev[rd]));
      rd = got_ev.size();
    end
  endtask

  task automatic test_auto_repeat();
    int c, e;
    c = cyc;
    btn_fire_raw = 1'b1;
    exp_ev.push_back((c + 11) * 4);
    exp_ev.push_back((c + 11) * 4 + 2);
    for (int p = c + 11; p <= c + 36; p += 5) exp_ev.push_back(p * 4 + 1);
    step_to(c + 9);
    checks++;
    if (fire !== 1'b0) begin
      failures++;
      $display("FAIL repeat_fire_early: got %b, expected 0", fire);
    end
    step();
    checks++;
    if (fire !== 1'b1) begin
      failures++;
      $display("FAIL repeat_fire_rise: got %b, expected 1", fire);
    end
    step_to(c + 30);
    btn_fire_raw = 1'b0;
    step_to(c + 39);
    checks++;
    if (fire !== 1'b1) begin
      failures++;
      $display("FAIL repeat_fire_hold: got %b, expected 1", fire);
    end
    step();
    checks++;
    if (fire !== 1'b0) begin
      failures++;
      $display("FAIL repeat_fire_fall: got %b, expected 0", fire);
    end
    step_to(c + 60);
    exp_ev.sort();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (rd >= got_ev.size()) begin
        failures++;
        $display("FAIL repeat_pulses: got nothing, expected %s", evs(e));
      end else begin
        if (got_ev[rd] !== e) begin
          failures++;
          $display("FAIL repeat_pulses: got %s, expected %s", evs(got_ev[rd]), evs(e));
        end
        rd++;
      end
    end
    checks++;
    if (rd != got_ev.size()) begin
      failures++;
      $display("FAIL repeat_pulses: got extra %s, expected none", evs(got_ev[rd]));
      rd = got_ev.size();
    end
  endtask

  task automatic test_simultaneous();
    int c, e;
    c = cyc;
    btn_left_raw = 1'b1;
    btn_fire_raw = 1'b1;
    exp_ev.push_back((c + 11) * 4);
    exp_ev.push_back((c + 11) * 4 + 2);
    for (int p = c + 11; p <= c + 21; p += 5) exp_ev.push_back(p * 4 + 1);
    step_to(c + 9);
    checks++;
    if ({left, fire} !== 2'b00) begin
      failures++;
      $display("FAIL simul_early: got left,fire=%b, expected 00", {left, fire});
    end
    step();
    checks++;
    if ({left, right, fire} !== 3'b101) begin
      failures++;
      $display("FAIL simul_rise: got left,right,fire=%b, expected 101", {left, right, fire});
    end
    step_to(c + 12);
    btn_left_raw = 1'b0;
    btn_fire_raw = 1'b0;
    step_to(c + 21);
    checks++;
    if ({left, fire} !== 2'b11) begin
      failures++;
      $display("FAIL simul_hold: got left,fire=%b, expected 11", {left, fire});
    end
    step();
    checks++;
    if ({left, fire} !== 2'b00) begin
      failures++;
      $display("FAIL simul_fall: got left,fire=%b, expected 00", {left, fire});
    end
    step_to(c + 40);
    exp_ev.sort();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (rd >= got_ev.size()) begin
        failures++;
        $display("FAIL simul_pulses: got nothing, expected %s", evs(e));
      end else begin
        if (got_ev[rd] !== e) begin
          failures++;
          $display("FAIL simul_pulses: got %s, expected %s", evs(got_ev[rd]), evs(e));
        end
        rd++;
      end
    end
    checks++;
    if (rd != got_ev.size()) begin
      failures++;
      $display("FAIL simul_pulses: got extra %s, expected none", evs(got_ev[rd]));
      rd = got_ev.size();
    end
  endtask

  task automatic test_reset_midop();
    int c, e;
    c = cyc;
    btn_fire_raw = 1'b1;
    exp_ev.push_back((c + 11) * 4);
    exp_ev.push_back((c + 11) * 4 + 1);
    exp_ev.push_back((c + 11) * 4 + 2);
    step_to(c + 14);
    checks++;
    if (fire !== 1'b1) begin
      failures++;
      $display("FAIL midop_fire_before: got %b, expected 1", fire);
    end
    arst_n = 1'b0;
    btn_fire_raw = 1'b0;
    #1;
    checks++;
    if ({left, right, fire, fire_pulse, any_press} !== 5'b0) begin
      failures++;
      $display("FAIL midop_reset_clear: got %b, expected 00000", {left, right, fire, fire_pulse, any_press});
    end
    step();
    checks++;
    if ({left, right, fire, fire_pulse, any_press} !== 5'b0) begin
      failures++;
      $display("FAIL midop_reset_hold: got %b, expected 00000", {left, right, fire, fire_pulse, any_press});
    end
    arst_n = 1'b1;
    step_to(c + 45);
    checks++;
    if (fire !== 1'b0) begin
      failures++;
      $display("FAIL midop_fire_after: got %b, expected 0", fire);
    end
    exp_ev.sort();
    while (exp_ev.size() > 0) begin
      e = exp_ev.pop_front();
      checks++;
      if (rd >= got_ev.size()) begin
        failures++;
        $display("FAIL midop_pulses: got nothing, expected %s", evs(e));
      end else begin
        if (got_ev[rd] !== e) begin
          failures++;
          $display("FAIL midop_pulses: got %s, expected %s", evs(got_ev[rd]), evs(e));
        end
        rd++;
      end
    end
    checks++;
    if (rd != got_ev.size()) begin
      failures++;
      $display("FAIL midop_pulses: got extra %s, expected none", evs(got_ev[rd]));
      rd = got_ev.size();
    end
  endtask

  initial begin
    arst_n = 1'b1;
    btn_left_raw = 1'b0; btn_right_raw = 1'b0; btn_fire_raw = 1'b0;
    #2 arst_n = 1'b0;
    test_reset();
    test_glitch();
    test_release();
    test_auto_repeat();
    test_simultaneous();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
